ioctl_upload_reader: RTL and testbench
======================================

IOCTL_UPLOAD_READER -- requirements
Module: ioctl_upload_reader

Interface
REQ-001 Parameter BASE_WORD, default 23'h000000, SDRAM word offset added to every fetch address.
REQ-002 Parameter ACK_TIMEOUT, default 255, max clk_sys cycles to wait for port_ack before abort.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_upl  in  1  upload window active (data_io reading from core).
REQ-006 ioctl_rd  in  1  one-cycle byte read strobe.
REQ-007 ioctl_addr  in  25  byte address of the strobed read.
REQ-008 ioctl_din  out  8  byte returned to data_io.
REQ-009 busy  out  1  fetch in progress or pending.
REQ-010 port_req  out  1  SDRAM request, toggle protocol.
REQ-011 port_ack  in  1  SDRAM acknowledge; equals port_req when idle.
REQ-012 port_a  out  23  SDRAM word address.
REQ-013 port_ds  out  2  byte strobes, constant 2'b11.
REQ-014 port_we  out  1  write enable, constant 0.
REQ-015 port_q  in  16  SDRAM read word, valid when port_ack==port_req.
REQ-016 byte_count  out  25  bytes served in current upload.
REQ-017 overrun  out  1  sticky: a strobe was dropped.
REQ-018 timeout  out  1  sticky: a fetch aborted on ACK_TIMEOUT.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, DRAIN; IDLE after reset.
REQ-020 One-word cache: tag (23 bit) + valid + data (16 bit); hit = valid and tag==ioctl_addr[23:1].
REQ-021 ioctl_rd in IDLE on hit: ioctl_din = cached byte (addr[0]=1 -> [15:8], else [7:0]) on next cycle, no SDRAM request.
REQ-022 ioctl_rd in IDLE on miss: ISSUE; port_a = BASE_WORD + ioctl_addr[23:1] (mod 2^23), port_req toggles, enter WAIT; busy high from the cycle after strobe.
REQ-023 WAIT exits when port_ack==port_req: latch port_q to cache, set tag/valid, drive ioctl_din next cycle, busy low, IDLE; fetch latency = SDRAM latency + 2 cycles.
REQ-024 ioctl_rd while busy: stored in one-deep pending register (address); served immediately after current fetch completes (hit check first).
REQ-025 ioctl_rd while pending already full: strobe dropped, overrun set, byte_count not incremented.
REQ-026 byte_count increments once per served byte, wraps at 2^25.
REQ-027 ioctl_rd while ioctl_upl low: ignored.
REQ-028 Rising ioctl_upl: byte_count, overrun, timeout cleared; cache invalidated.
REQ-029 Falling ioctl_upl with fetch outstanding: enter DRAIN, wait for ack, discard data, clear pending, cache invalid, IDLE; port_req never toggled again during DRAIN.
REQ-030 WAIT counter exceeding ACK_TIMEOUT: set timeout, ioctl_din = 8'hFF, port_req forced equal to port_ack, cache invalid, IDLE.
REQ-031 Simultaneous completion and new ioctl_rd: completion handled first; new strobe goes to pending.

Reset
REQ-032 Reset: FSM IDLE, cache invalid, pending empty, ioctl_din 8'h00, busy 0, byte_count 0, overrun 0, timeout 0, port_a 0.
REQ-033 Reset loads port_req from port_ack so no handshake is left open, including reset mid-fetch.

Structure
REQ-034 FSM state enum and ACK_TIMEOUT default live in shared package ioctl_pkg.
REQ-035 Single module; cache tag compare inline; no sub-module.

Verification
REQ-036 Reset, upl=1, rd addr 0x000004, ack after 5 cycles with q=16'hBEEF -> one req toggle, port_a=0x000002, din=8'hEF, busy 7 cycles, byte_count=1.
REQ-037 Then rd 0x000005 -> no req toggle, din=8'hBE next cycle, byte_count=2.
REQ-038 Miss rd 0x10, rd 0x20 during WAIT, rd 0x30 also during WAIT -> two fetches (0x08,0x10), overrun=1, byte_count+2.
REQ-039 BASE_WORD=23'h400000, rd 0x000002 -> port_a=0x400001.
REQ-040 upl falls mid-WAIT, ack 10 cycles later -> no further toggles, cache invalid, busy low after ack, byte_count unchanged.
REQ-041 No ack for 256 cycles -> timeout=1, din=8'hFF, port_req==port_ack; reset mid-WAIT -> port_req==port_ack next cycle.

Source files
------------

// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl upload reader: FSM states, default ack timeout
// and the byte-lane selector used when returning data to data_io.
package ioctl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } readState_e;

    localparam int ACK_TIMEOUT_DEFAULT = 255;

    function automatic logic [7:0] selectByte(input logic [15:0] word, input logic hiByte);
        return hiByte ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/ioctl_upload_reader.sv
// Serves data_io upload byte reads from SDRAM through a one-word cache, with a
// one-deep pending strobe slot and a toggle-handshake SDRAM port.
module ioctl_upload_reader
    import ioctl_pkg::*;
#(
    parameter logic [22:0] BASE_WORD   = 23'h000000,
    parameter int          ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upl,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        busy,
    output logic        port_req,
    input  logic        port_ack,
    output logic [22:0] port_a,
    output logic [1:0]  port_ds,
    output logic        port_we,
    input  logic [15:0] port_q,
    output logic [24:0] byte_count,
    output logic        overrun,
    output logic        timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1) + 1;

    readState_e  state_q, state_d;
    logic        portReq_q, portReq_d;
    logic [22:0] portA_q, portA_d;
    logic [22:0] cacheTag_q, cacheTag_d;
    logic [15:0] cacheData_q, cacheData_d;
    logic        cacheValid_q, cacheValid_d;
    logic        pendValid_q, pendValid_d;
    logic [23:0] pendAddr_q, pendAddr_d;
    logic [23:0] curAddr_q, curAddr_d;
    logic [7:0]  din_q, din_d;
    logic [24:0] count_q, count_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic [CW-1:0] waitCnt_q, waitCnt_d;
    logic        upl_q;

    logic        rdOk;
    logic        uplRise;
    logic        ackDone;
    logic        waitExpired;
    logic [23:0] reqAddr;
    logic        reqHit;
    logic        served;
    logic        unusedAddrMsb;

    // Bit 24 lies beyond the 16 MB window the SDRAM word address can reach.
    assign unusedAddrMsb = ioctl_addr[24];

    assign rdOk        = ioctl_rd && ioctl_upl;
    assign uplRise     = ioctl_upl && !upl_q;
    assign ackDone     = (port_ack == portReq_q);
    assign waitExpired = (waitCnt_q == CW'(ACK_TIMEOUT));
    assign reqAddr     = pendValid_q ? pendAddr_q : ioctl_addr[23:0];
    assign reqHit      = cacheValid_q && !uplRise && (cacheTag_q == reqAddr[23:1]);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            portReq_q    <= port_ack;
            portA_q      <= '0;
            cacheTag_q   <= '0;
            cacheData_q  <= '0;
            cacheValid_q <= 1'b0;
            pendValid_q  <= 1'b0;
            pendAddr_q   <= '0;
            curAddr_q    <= '0;
            din_q        <= 8'h00;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            waitCnt_q    <= '0;
            upl_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            portReq_q    <= portReq_d;
            portA_q      <= portA_d;
            cacheTag_q   <= cacheTag_d;
            cacheData_q  <= cacheData_d;
            cacheValid_q <= cacheValid_d;
            pendValid_q  <= pendValid_d;
            pendAddr_q   <= pendAddr_d;
            curAddr_q    <= curAddr_d;
            din_q        <= din_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            waitCnt_q    <= waitCnt_d;
            upl_q        <= ioctl_upl;
        end
    end

    always_comb begin
        state_d      = state_q;
        portReq_d    = portReq_q;
        portA_d      = portA_q;
        cacheTag_d   = cacheTag_q;
        cacheData_d  = cacheData_q;
        cacheValid_d = cacheValid_q && !uplRise;
        pendValid_d  = pendValid_q;
        pendAddr_d   = pendAddr_q;
        curAddr_d    = curAddr_q;
        din_d        = din_q;
        count_d      = uplRise ? '0 : count_q;
        overrun_d    = overrun_q && !uplRise;
        timeout_d    = timeout_q && !uplRise;
        waitCnt_d    = waitCnt_q;
        served       = 1'b0;

        // Strobes arriving while a fetch is underway park in the pending slot.
        if (state_q != IDLE && rdOk) begin
            if (!pendValid_q) begin
                pendValid_d = 1'b1;
                pendAddr_d  = ioctl_addr[23:0];
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (!ioctl_upl) begin
                    pendValid_d = 1'b0;
                end else if (pendValid_q || rdOk) begin
                    if (reqHit) begin
                        din_d  = selectByte(cacheData_q, reqAddr[0]);
                        served = 1'b1;
                    end else begin
                        curAddr_d = reqAddr;
                        state_d   = ISSUE;
                    end
                    // A pending strobe was just consumed, so a fresh one takes its slot.
                    pendValid_d = pendValid_q && rdOk;
                    if (pendValid_q && rdOk) begin
                        pendAddr_d = ioctl_addr[23:0];
                    end
                end
            end
            ISSUE: begin
                if (!ioctl_upl) begin
                    pendValid_d  = 1'b0;
                    cacheValid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    portA_d   = BASE_WORD + curAddr_q[23:1];
                    portReq_d = ~portReq_q;
                    waitCnt_d = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!ioctl_upl) begin
                    pendValid_d  = 1'b0;
                    cacheValid_d = 1'b0;
                    state_d      = DRAIN;
                end else if (ackDone) begin
                    cacheData_d  = port_q;
                    cacheTag_d   = curAddr_q[23:1];
                    cacheValid_d = 1'b1;
                    din_d        = selectByte(port_q, curAddr_q[0]);
                    served       = 1'b1;
                    state_d      = IDLE;
                end else if (waitExpired) begin
                    // Closing the handshake locally keeps a late ack from looking like a new one.
                    portReq_d    = port_ack;
                    timeout_d    = 1'b1;
                    din_d        = 8'hFF;
                    cacheValid_d = 1'b0;
                    served       = 1'b1;
                    state_d      = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (ackDone) begin
                    cacheValid_d = 1'b0;
                    state_d      = IDLE;
                end else if (waitExpired) begin
                    portReq_d    = port_ack;
                    timeout_d    = 1'b1;
                    cacheValid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (served) begin
            count_d = count_d + 25'd1;
        end
    end

    assign ioctl_din  = din_q;
    assign busy       = (state_q != IDLE) || pendValid_q;
    assign port_req   = portReq_q;
    assign port_a     = portA_q;
    assign port_ds    = 2'b11;
    assign port_we    = 1'b0;
    assign byte_count = count_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: a scoreboard of expected bytes is filled as strobes
// are issued and drained by a monitor whenever byte_count advances.
module tb_ioctl_upload_reader;
    import ioctl_pkg::*;

    localparam int          ACK_TO = ACK_TIMEOUT_DEFAULT;
    localparam logic [22:0] BASE2  = 23'h400000;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_upl = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_din;
    logic        busy;
    logic        port_req;
    logic        port_ack = 1'b1;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic        port_we;
    logic [15:0] port_q = '0;
    logic [24:0] byte_count;
    logic        overrun;
    logic        timeout;

    logic        upl2 = 1'b1;
    logic        rd2 = 1'b0;
    logic [24:0] addr2 = '0;
    logic [7:0]  din2;
    logic        busy2;
    logic        req2;
    logic        ack2 = 1'b0;
    logic [22:0] a2;
    logic [1:0]  ds2;
    logic        we2;
    logic [15:0] q2 = '0;
    logic [24:0] count2;
    logic        ovr2;
    logic        to2;

    int          checks = 0;
    int          fails = 0;
    logic [7:0]  expQ[$];
    logic [22:0] reqLog[$];
    int          toggles = 0;
    logic        prevReq = 1'b0;
    bit          sdramEnable = 1'b1;
    int          sdramLatency = 5;
    int          sdramCnt = 0;
    logic [24:0] lastCount = '0;
    logic [15:0] memOverride[logic [22:0]];

    always #5 clk_sys = ~clk_sys;

    ioctl_upload_reader dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upl(ioctl_upl), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .busy(busy), .port_req(port_req),
        .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds), .port_we(port_we),
        .port_q(port_q), .byte_count(byte_count), .overrun(overrun), .timeout(timeout)
    );

    ioctl_upload_reader #(.BASE_WORD(BASE2)) dut2 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upl(upl2), .ioctl_rd(rd2),
        .ioctl_addr(addr2), .ioctl_din(din2), .busy(busy2), .port_req(req2),
        .port_ack(ack2), .port_a(a2), .port_ds(ds2), .port_we(we2),
        .port_q(q2), .byte_count(count2), .overrun(ovr2), .timeout(to2)
    );

    function automatic logic [15:0] memWord(input logic [22:0] w);
        if (memOverride.exists(w)) return memOverride[w];
        return 16'((w * 23'd40503) ^ (w >> 3) ^ 23'h5A5A);
    endfunction

    // Byte the upload should see for a byte address, given SDRAM contents and BASE_WORD 0.
    function automatic logic [7:0] modelByte(input logic [24:0] a);
        logic [15:0] w;
        w = memWord(a[23:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [24:0] addr, input bit expectServe);
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        if (expectServe) expQ.push_back(modelByte(addr));
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
    endtask

    task automatic waitBusyLow(input int maxCycles, output int cycles);
        cycles = 0;
        while (busy && cycles < maxCycles) begin
            cycles++;
            @(negedge clk_sys);
        end
        if (busy) begin
            checks++;
            fails++;
            $display("[TB] FAIL busyWait: busy still 1 after %0d cycles, required 0", cycles);
        end
    endtask

    // SDRAM responder: acks a toggled request sdramLatency cycles after noticing it.
    always @(negedge clk_sys) begin
        if (reset) begin
            sdramCnt = 0;
        end else if (sdramCnt > 0) begin
            sdramCnt = sdramCnt - 1;
            if (sdramCnt == 0) begin
                port_q   = memWord(port_a);
                port_ack = port_req;
            end
        end else if (sdramEnable && port_req != port_ack) begin
            sdramCnt = sdramLatency;
        end
    end

    always @(negedge clk_sys) begin
        if (port_req !== prevReq) begin
            toggles++;
            reqLog.push_back(port_a);
        end
        prevReq = port_req;
    end

    // Monitor: every advance of byte_count is one served byte to compare against the queue.
    always @(negedge clk_sys) begin
        if (reset) begin
            lastCount = '0;
        end else if (byte_count != lastCount) begin
            if (byte_count == lastCount + 25'd1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL scoreboard: byte 0x%02h served, no byte expected", ioctl_din);
                end else begin
                    checkOutput("scoreboard din", 32'(ioctl_din), 32'(expQ.pop_front()));
                end
            end else if (byte_count != '0) begin
                checks++;
                fails++;
                $display("[TB] FAIL byteCountStep: got %0d, expected %0d", byte_count, lastCount + 25'd1);
            end
            lastCount = byte_count;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int t0;
        int logBase;
        logic [24:0] c0;
        int randomCount;

        memOverride[23'h000002] = 16'hBEEF;
        ioctl_upl = 1'b1;
        repeat (3) @(negedge clk_sys);

        checkOutput("reset req==ack", 32'(port_req == port_ack), 1);
        checkOutput("reset din", 32'(ioctl_din), 8'h00);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset byte_count", 32'(byte_count), 0);
        checkOutput("reset port_a", 32'(port_a), 0);
        checkOutput("reset flags", 32'({overrun, timeout}), 0);
        checkOutput("port_ds", 32'(port_ds), 2'b11);
        checkOutput("port_we", 32'(port_we), 0);
        reset = 1'b0;
        @(negedge clk_sys);

        $display("[TB] miss fetch of 0x000004");
        t0 = toggles;
        applyStimulus(25'h000004, 1'b1);
        waitBusyLow(50, n);
        checkOutput("miss busy cycles", n, 7);
        checkOutput("miss req toggles", toggles - t0, 1);
        checkOutput("miss port_a", 32'(reqLog[reqLog.size() - 1]), 23'h000002);
        checkOutput("miss din", 32'(ioctl_din), 8'hEF);
        checkOutput("miss byte_count", 32'(byte_count), 1);

        $display("[TB] hit on 0x000005");
        t0 = toggles;
        applyStimulus(25'h000005, 1'b1);
        checkOutput("hit din", 32'(ioctl_din), 8'hBE);
        checkOutput("hit byte_count", 32'(byte_count), 2);
        repeat (3) @(negedge clk_sys);
        checkOutput("hit req toggles", toggles - t0, 0);

        $display("[TB] pending and overrun");
        t0 = toggles;
        logBase = reqLog.size();
        c0 = byte_count;
        applyStimulus(25'h000010, 1'b1);
        applyStimulus(25'h000020, 1'b1);
        repeat (2) @(negedge clk_sys);
        applyStimulus(25'h000030, 1'b0);
        waitBusyLow(100, n);
        checkOutput("pending fetch count", toggles - t0, 2);
        if (reqLog.size() >= logBase + 2) begin
            checkOutput("pending port_a first", 32'(reqLog[logBase]), 23'h000008);
            checkOutput("pending port_a second", 32'(reqLog[logBase + 1]), 23'h000010);
        end
        checkOutput("overrun flag", 32'(overrun), 1);
        checkOutput("pending byte_count", 32'(byte_count), 32'(c0 + 25'd2));

        $display("[TB] BASE_WORD offset");
        for (int k = 0; k < 2; k++) begin
            addr2 = (k == 0) ? 25'h0000002 : 25'h0FFFFFF;
            rd2 = 1'b1;
            @(negedge clk_sys);
            rd2 = 1'b0;
            n = 0;
            while (req2 == ack2 && n < 10) begin
                n++;
                @(negedge clk_sys);
            end
            checkOutput("base port_a", 32'(a2), 32'(23'(BASE2 + addr2[23:1])));
            q2   = (k == 0) ? 16'h1234 : 16'hABCD;
            ack2 = req2;
            n = 0;
            while (busy2 && n < 10) begin
                n++;
                @(negedge clk_sys);
            end
            checkOutput("base din", 32'(din2), 32'(addr2[0] ? q2[15:8] : q2[7:0]));
        end

        $display("[TB] upload window closes mid-fetch");
        sdramLatency = 12;
        t0 = toggles;
        c0 = byte_count;
        applyStimulus(25'h000040, 1'b0);
        repeat (3) @(negedge clk_sys);
        ioctl_upl = 1'b0;
        waitBusyLow(100, n);
        checkOutput("drain req toggles", toggles - t0, 1);
        checkOutput("drain byte_count", 32'(byte_count), 32'(c0));
        t0 = toggles;
        applyStimulus(25'h000041, 1'b0);
        repeat (4) @(negedge clk_sys);
        checkOutput("upl low rd toggles", toggles - t0, 0);
        checkOutput("upl low rd byte_count", 32'(byte_count), 32'(c0));
        checkOutput("upl low rd busy", 32'(busy), 0);
        ioctl_upl = 1'b1;
        @(negedge clk_sys);
        checkOutput("upl rise byte_count", 32'(byte_count), 0);
        checkOutput("upl rise overrun", 32'(overrun), 0);
        sdramLatency = 2;
        t0 = toggles;
        applyStimulus(25'h000040, 1'b1);
        waitBusyLow(50, n);
        checkOutput("refetch after drain", toggles - t0, 1);

        $display("[TB] ack timeout");
        sdramEnable = 1'b0;
        expQ.push_back(8'hFF);
        applyStimulus(25'h000082, 1'b0);
        n = 0;
        while (!timeout && n < 400) begin
            n++;
            @(negedge clk_sys);
        end
        checkOutput("timeout flag", 32'(timeout), 1);
        checkOutput("timeout latency in range", 32'(n >= ACK_TO && n <= ACK_TO + 4), 1);
        checkOutput("timeout din", 32'(ioctl_din), 8'hFF);
        checkOutput("timeout req==ack", 32'(port_req == port_ack), 1);
        checkOutput("timeout busy", 32'(busy), 0);

        applyStimulus(25'h000084, 1'b0);
        repeat (4) @(negedge clk_sys);
        checkOutput("open handshake", 32'(port_req != port_ack), 1);
        reset = 1'b1;
        @(negedge clk_sys);
        checkOutput("midfetch reset req==ack", 32'(port_req == port_ack), 1);
        checkOutput("midfetch reset busy", 32'(busy), 0);
        checkOutput("midfetch reset state", 32'({byte_count, ioctl_din, timeout, overrun}), 0);
        checkOutput("midfetch reset port_a", 32'(port_a), 0);
        reset = 1'b0;
        sdramEnable = 1'b1;
        @(negedge clk_sys);

        $display("[TB] random upload traffic");
        randomCount = 0;
        for (int i = 0; i < 400; i++) begin
            if (expQ.size() < 2 && $urandom_range(0, 2) == 0) begin
                sdramLatency = $urandom_range(1, 6);
                applyStimulus(25'h000100 + 25'($urandom_range(0, 15)), 1'b1);
                randomCount++;
            end else begin
                @(negedge clk_sys);
            end
        end
        n = 0;
        while ((busy || expQ.size() != 0) && n < 200) begin
            n++;
            @(negedge clk_sys);
        end
        checkOutput("random queue drained", expQ.size(), 0);
        checkOutput("random byte_count", 32'(byte_count), randomCount);
        checkOutput("random overrun", 32'(overrun), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
